// File: rtl/intrpt_pkg.sv
// Shared types and defaults for the interrupt host.
// Optional statistics counters: define INTRT_HOST_STATS_EN.
package intrpt_pkg;

  localparam int DEF_DATA_WIDTH = 4;
  localparam int DEF_NUM_SLAVE  = 16;
  localparam int DEF_SVC_CYCLES = 4;
  localparam int DEF_TIMEOUT    = 16;

  localparam logic [2:0] PSEL_ACTIVE = 3'b001;

  typedef enum logic [1:0] {
    APB_IDLE,
    APB_SETUP,
    APB_ACCESS
  } apb_state_e;

  typedef enum logic [1:0] {
    SVC_WAIT,
    SVC_SERVICE,
    SVC_ACK
  } svc_state_e;

endpackage

// File: rtl/intrpt_svc_fsm.sv
// Interrupt service sequencer: latch ID, wait SVC_CYCLES,
// pulse the one-hot clear, then hold the acknowledge.
module intrpt_svc_fsm
  import intrpt_pkg::*;
#(
  parameter int NUM_SLAVE  = DEF_NUM_SLAVE,
  parameter int SVC_CYCLES = DEF_SVC_CYCLES,
  localparam int AW = (NUM_SLAVE > 1) ? $clog2(NUM_SLAVE) : 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 intrt_valid,
  input  logic [AW-1:0]        intrt_id,
  output logic                 intrt_servised,
  output logic [NUM_SLAVE-1:0] intrt_clear,
  output logic                 svc_busy
);

  localparam logic [NUM_SLAVE-1:0] ONE = 1;
  localparam logic [7:0] CNT_INIT = 8'(SVC_CYCLES - 1);

  svc_state_e    state;
  logic [AW-1:0] id_q;
  logic [7:0]    cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= SVC_WAIT;
      id_q           <= '0;
      cnt            <= '0;
      intrt_clear    <= '0;
      intrt_servised <= 1'b0;
      svc_busy       <= 1'b0;
    end else begin
      intrt_clear <= '0;
      unique case (state)
        SVC_WAIT: begin
          if (intrt_valid) begin
            state    <= SVC_SERVICE;
            id_q     <= intrt_id;
            cnt      <= CNT_INIT;
            svc_busy <= 1'b1;
          end
        end
        SVC_SERVICE: begin
          if (cnt == 8'd0) begin
            state          <= SVC_ACK;
            intrt_clear    <= ONE << id_q;
            intrt_servised <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        SVC_ACK: begin
          if (!intrt_valid) begin
            state          <= SVC_WAIT;
            intrt_servised <= 1'b0;
            svc_busy       <= 1'b0;
          end
        end
        default: state <= SVC_WAIT;
      endcase
    end
  end

endmodule

// File: rtl/intrpt_host.sv
// Interrupt host: APB priority-register master plus service FSM.
// Optional svc_count/err_count outputs: define INTRT_HOST_STATS_EN.
module intrpt_host
  import intrpt_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_SLAVE  = DEF_NUM_SLAVE,
  parameter int SVC_CYCLES = DEF_SVC_CYCLES,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  localparam int AW = (NUM_SLAVE > 1) ? $clog2(NUM_SLAVE) : 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cfg_req,
  input  logic                  cfg_write,
  input  logic [AW-1:0]         cfg_addr,
  input  logic [DATA_WIDTH-1:0] cfg_wdata,
  output logic                  cfg_ack,
  output logic [DATA_WIDTH-1:0] cfg_rdata,
  output logic                  cfg_err,
  output logic [2:0]            psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [AW-1:0]         paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pready,
  input  logic                  perror,
  input  logic [AW-1:0]         prdata,
  input  logic                  intrt_valid,
  input  logic [AW-1:0]         intrt_to_be_servised,
  output logic                  intrt_servised,
  output logic [NUM_SLAVE-1:0]  intrt_clear,
  output logic                  svc_busy
`ifdef INTRT_HOST_STATS_EN
  ,
  output logic [15:0]           svc_count,
  output logic [7:0]            err_count
`endif
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  apb_state_e            state;
  logic [TW-1:0]         tcnt;
  logic                  tmo;
  logic [DATA_WIDTH-1:0] prdata_x;

  generate
    if (AW >= DATA_WIDTH) begin : g_trunc
      assign prdata_x = prdata[DATA_WIDTH-1:0];
    end else begin : g_zext
      assign prdata_x = {{(DATA_WIDTH-AW){1'b0}}, prdata};
    end
  endgenerate

  assign tmo = !pready && (tcnt == TLAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= APB_IDLE;
      tcnt      <= '0;
      psel      <= '0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      cfg_ack   <= 1'b0;
      cfg_err   <= 1'b0;
      cfg_rdata <= '0;
    end else begin
      cfg_ack <= 1'b0;
      cfg_err <= 1'b0;
      unique case (state)
        APB_IDLE: begin
          // the ack cycle blocks a restart from the still-high request
          if (cfg_req && !cfg_ack) begin
            state  <= APB_SETUP;
            psel   <= PSEL_ACTIVE;
            pwrite <= cfg_write;
            paddr  <= cfg_addr;
            pwdata <= cfg_wdata;
          end
        end
        APB_SETUP: begin
          state   <= APB_ACCESS;
          penable <= 1'b1;
          tcnt    <= '0;
        end
        APB_ACCESS: begin
          if (pready || tmo) begin
            state   <= APB_IDLE;
            psel    <= '0;
            penable <= 1'b0;
            cfg_ack <= 1'b1;
            cfg_err <= perror | tmo;
            if (!pwrite) cfg_rdata <= prdata_x;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: state <= APB_IDLE;
      endcase
    end
  end

  intrpt_svc_fsm #(
    .NUM_SLAVE  (NUM_SLAVE),
    .SVC_CYCLES (SVC_CYCLES)
  ) u_svc (
    .clk            (clk),
    .rstn           (rstn),
    .intrt_valid    (intrt_valid),
    .intrt_id       (intrt_to_be_servised),
    .intrt_servised (intrt_servised),
    .intrt_clear    (intrt_clear),
    .svc_busy       (svc_busy)
  );

`ifdef INTRT_HOST_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      svc_count <= '0;
      err_count <= '0;
    end else begin
      if (|intrt_clear) svc_count <= svc_count + 16'd1;
      if (cfg_ack && cfg_err && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule
